// File: rtl/fp_pkg.sv
// Shared definitions for the FP multiplier scheduler.
// Contents: IEEE-754 exception flag bit positions, the canonical quiet NaN
// used as the timeout result, and the scheduler FSM state encoding.
package fp_pkg;

  // Flag vector layout {NV,DZ,OF,UF,NX}
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  // A timed-out operation is reported as an invalid operation
  localparam logic [4:0]  FLAGS_TMO = 5'(1) << FLAG_NV;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/fp_rsp_buf.sv
// One-entry valid/ready response holding register.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_wr                 load i_y/i_flags/i_tag and mark the entry valid
//   i_y, i_flags, i_tag  response payload
//   i_ready              consumer takes the response when o_valid is high
//   o_valid              entry occupied
//   o_y, o_flags, o_tag  held payload, stable while o_valid & ~i_ready
module fp_rsp_buf
  import fp_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [31:0]      i_y,
  input  logic [4:0]       i_flags,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [31:0]      o_y,
  output logic [4:0]       o_flags,
  output logic [TAG_W-1:0] o_tag
);

  // NOTE: payload registers are reset as well as the valid bit, so the
  // response outputs read as zero out of reset rather than X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_y     <= '0;
      o_flags <= '0;
      o_tag   <= '0;
    end else if (i_wr) begin
      // The scheduler never grants a requester whose entry is full, so a
      // write and a drain cannot land on the same entry in one cycle.
      o_valid <= 1'b1;
      o_y     <= i_y;
      o_flags <= i_flags;
      o_tag   <= i_tag;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one single-precision FP multiplier between
// two requesters (0: FPU issue port, 1: microcoded coprocessor).
// Ports:
//   req_valid/req_ready   per-requester request handshake (ready = grant)
//   req_a/req_b/req_tag   packed per-requester operands and tag ([31:0] = req 0)
//   rsp_valid/rsp_ready   per-requester one-entry response buffer handshake
//   rsp_y/rsp_flags/rsp_tag  packed per-requester response payload
//   mul_start/mul_a/mul_b    start pulse and registered operands to multiplier
//   mul_y/mul_flags/mul_valid result from multiplier (valid is one cycle)
//   fflags_acc/fflags_clr    sticky OR of delivered flags, synchronous clear
//   tmo_err                  sticky multiplier timeout, cleared only by reset
module fp_mul_sched
  import fp_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int TMO_CYC = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [63:0]        req_a,
  input  logic [63:0]        req_b,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [63:0]        rsp_y,
  output logic [9:0]         rsp_flags,
  output logic [2*TAG_W-1:0] rsp_tag,
  output logic               mul_start,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  input  logic [31:0]        mul_y,
  input  logic [4:0]         mul_flags,
  input  logic               mul_valid,
  output logic [4:0]         fflags_acc,
  input  logic               fflags_clr,
  output logic               tmo_err
);

  state_e             r_state, w_state_nxt;
  logic               r_ptr, w_ptr_nxt;
  logic               r_win, w_win;
  logic [TAG_W-1:0]   r_tag;
  logic [7:0]         r_cnt;
  logic [1:0]         w_elig;
  logic               w_grant;
  logic [1:0]         w_wr;
  logic [31:0]        w_wr_y;
  logic [4:0]         w_wr_flags;
  logic               w_tmo;

  // A requester still holding an undrained response is not eligible.
  assign w_elig    = req_valid & ~rsp_valid;
  assign mul_start = (r_state == S_ISSUE);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_win       = r_ptr;
    w_grant     = 1'b0;
    req_ready   = 2'b00;
    w_wr        = 2'b00;
    w_wr_y      = mul_y;
    w_wr_flags  = mul_flags;
    w_tmo       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        unique case (w_elig)
          2'b01:   w_win = 1'b0;
          2'b10:   w_win = 1'b1;
          default: w_win = r_ptr;
        endcase
        if (|w_elig) begin
          w_grant          = 1'b1;
          req_ready[w_win] = 1'b1;
          w_ptr_nxt        = ~w_win;
          w_state_nxt      = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // A result arriving on the last allowed cycle still wins over timeout.
        if (mul_valid) begin
          w_wr[r_win] = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 8'(TMO_CYC - 1)) begin
          w_wr[r_win] = 1'b1;
          w_wr_y      = QNAN;
          w_wr_flags  = FLAGS_TMO;
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= 1'b0;
      r_win      <= 1'b0;
      r_tag      <= '0;
      r_cnt      <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      fflags_acc <= '0;
      tmo_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_grant) begin
        r_win <= w_win;
        r_tag <= req_tag[w_win*TAG_W +: TAG_W];
        mul_a <= req_a[w_win*32 +: 32];
        mul_b <= req_b[w_win*32 +: 32];
      end
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 8'd1;
      // A flag set in the same cycle as a clear survives the clear.
      fflags_acc <= (fflags_clr ? 5'b0 : fflags_acc) | ((|w_wr) ? w_wr_flags : 5'b0);
      if (w_tmo) tmo_err <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    fp_rsp_buf #(.TAG_W(TAG_W)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr    (w_wr[gi]),
      .i_y     (w_wr_y),
      .i_flags (w_wr_flags),
      .i_tag   (r_tag),
      .i_ready (rsp_ready[gi]),
      .o_valid (rsp_valid[gi]),
      .o_y     (rsp_y[gi*32 +: 32]),
      .o_flags (rsp_flags[gi*5 +: 5]),
      .o_tag   (rsp_tag[gi*TAG_W +: TAG_W])
    );
  end

endmodule
